// File: rtl/dcache_arbiter.sv
// dcache_arbiter: round-robin sharing of a single-ported dcache between the core LSU (port 0) and a debug/DMA master (port 1)
module dcache_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_m0_req,
    input  logic                i_m0_we,
    input  logic [ADDR_W-1:0]   i_m0_addr,
    input  logic [DATA_W-1:0]   i_m0_wdata,
    input  logic [DATA_W/8-1:0] i_m0_be,
    output logic                o_m0_ack,
    output logic                o_m0_err,
    output logic [DATA_W-1:0]   o_m0_rdata,
    input  logic                i_m1_req,
    input  logic                i_m1_we,
    input  logic [ADDR_W-1:0]   i_m1_addr,
    input  logic [DATA_W-1:0]   i_m1_wdata,
    input  logic [DATA_W/8-1:0] i_m1_be,
    output logic                o_m1_ack,
    output logic                o_m1_err,
    output logic [DATA_W-1:0]   o_m1_rdata,
    output logic [ADDR_W-1:0]   o_dc_addr,
    output logic                o_dc_wreq,
    output logic                o_dc_rreq,
    output logic [DATA_W-1:0]   o_dc_wdata,
    output logic [DATA_W/8-1:0] o_dc_byte_enable,
    input  logic                i_dc_wvalid,
    input  logic                i_dc_rvalid,
    input  logic [DATA_W-1:0]   i_dc_rdata
);
    localparam int BE_W = DATA_W / 8;
    localparam int CW   = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              r_state;
    logic                r_last;
    logic                r_gnt;
    logic [CW-1:0]       r_cnt;
    logic [ADDR_W-1:0]   r_dc_addr;
    logic                r_dc_wreq;
    logic                r_dc_rreq;
    logic [DATA_W-1:0]   r_dc_wdata;
    logic [BE_W-1:0]     r_dc_be;
    logic                r_m0_ack;
    logic                r_m0_err;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic                r_m1_ack;
    logic                r_m1_err;
    logic [DATA_W-1:0]   r_m1_rdata;

    logic                w_pick1;
    logic                w_we;
    logic                w_done;
    logic                w_tout;
    logic                w_upd_rdata;
    logic [DATA_W-1:0]   w_new_rdata;

    // port 1 wins when alone, or on a tie when port 0 was granted last
    assign w_pick1     = i_m1_req & (~i_m0_req | ~r_last);
    assign w_we        = w_pick1 ? i_m1_we : i_m0_we;
    // only a valid matching the in-flight request type completes it
    assign w_done      = r_dc_wreq ? i_dc_wvalid : i_dc_rvalid;
    assign w_tout      = r_cnt == CW'(TIMEOUT - 1);
    // reads capture cache data, timeouts zero it, write completions leave it alone
    assign w_upd_rdata = r_dc_rreq | ~w_done;
    assign w_new_rdata = w_done ? i_dc_rdata : '0;

    assign o_dc_addr        = r_dc_addr;
    assign o_dc_wreq        = r_dc_wreq;
    assign o_dc_rreq        = r_dc_rreq;
    assign o_dc_wdata       = r_dc_wdata;
    assign o_dc_byte_enable = r_dc_be;
    assign o_m0_ack         = r_m0_ack;
    assign o_m0_err         = r_m0_err;
    assign o_m0_rdata       = r_m0_rdata;
    assign o_m1_ack         = r_m1_ack;
    assign o_m1_err         = r_m1_err;
    assign o_m1_rdata       = r_m1_rdata;

    // arbitration FSM: grant in IDLE, wait for completion or timeout in ACCESS, pulse ack in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_gnt      <= 1'b0;
            r_cnt      <= '0;
            r_dc_addr  <= '0;
            r_dc_wreq  <= 1'b0;
            r_dc_rreq  <= 1'b0;
            r_dc_wdata <= '0;
            r_dc_be    <= '0;
            r_m0_ack   <= 1'b0;
            r_m0_err   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_ack   <= 1'b0;
            r_m1_err   <= 1'b0;
            r_m1_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_m0_req | i_m1_req) begin
                        r_gnt      <= w_pick1;
                        r_last     <= w_pick1;
                        r_dc_addr  <= w_pick1 ? i_m1_addr : i_m0_addr;
                        r_dc_wdata <= w_pick1 ? i_m1_wdata : i_m0_wdata;
                        r_dc_be    <= w_pick1 ? i_m1_be : i_m0_be;
                        r_dc_wreq  <= w_we;
                        r_dc_rreq  <= ~w_we;
                        r_cnt      <= '0;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_done | w_tout) begin
                        r_dc_wreq <= 1'b0;
                        r_dc_rreq <= 1'b0;
                        r_state   <= RESP;
                        if (r_gnt) begin
                            r_m1_ack <= 1'b1;
                            r_m1_err <= ~w_done;
                            if (w_upd_rdata) r_m1_rdata <= w_new_rdata;
                        end else begin
                            r_m0_ack <= 1'b1;
                            r_m0_err <= ~w_done;
                            if (w_upd_rdata) r_m0_rdata <= w_new_rdata;
                        end
                    end
                end
                RESP: begin
                    r_m0_ack <= 1'b0;
                    r_m0_err <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_m1_err <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_arbiter.sv
// tb_dcache_arbiter: directed self-checking bench for dcache_arbiter
module tb_dcache_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] dc_addr, dc_wdata, dc_rdata;
    logic        dc_wreq, dc_rreq, dc_wvalid, dc_rvalid;
    logic [3:0]  dc_be;
    int          checks = 0;
    int          errors = 0;
    int          acks0 = 0;
    int          acks1 = 0;

    dcache_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .i_m0_be(m0_be),
        .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_rdata(m0_rdata),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .i_m1_be(m1_be),
        .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_rdata(m1_rdata),
        .o_dc_addr(dc_addr), .o_dc_wreq(dc_wreq), .o_dc_rreq(dc_rreq), .o_dc_wdata(dc_wdata),
        .o_dc_byte_enable(dc_be), .i_dc_wvalid(dc_wvalid), .i_dc_rvalid(dc_rvalid), .i_dc_rdata(dc_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("wreq_rreq_exclusive", {31'd0, dc_wreq & dc_rreq}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        {m0_req, m0_we, m1_req, m1_we, dc_wvalid, dc_rvalid} = '0;
        {m0_addr, m0_wdata, m1_addr, m1_wdata, dc_rdata} = '0;
        {m0_be, m1_be} = '0;
        step(); step();
        check("rst_rreq", {31'd0, dc_rreq}, 32'd0);
        check("rst_wreq", {31'd0, dc_wreq}, 32'd0);
        check("rst_addr", dc_addr, 32'd0);
        check("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        rst_n = 1'b1;
        step();
        // single read on port 0
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4;
        step();
        check("rd_rreq", {31'd0, dc_rreq}, 32'd1);
        check("rd_wreq", {31'd0, dc_wreq}, 32'd0);
        check("rd_addr", dc_addr, 32'h4);
        check("rd_noack_yet", {31'd0, m0_ack}, 32'd0);
        dc_rvalid = 1'b1; dc_rdata = 32'h000000ff;
        step();
        dc_rvalid = 1'b0;
        check("rd_ack", {31'd0, m0_ack}, 32'd1);
        check("rd_err", {31'd0, m0_err}, 32'd0);
        check("rd_rdata", m0_rdata, 32'h000000ff);
        check("rd_rreq_drop", {31'd0, dc_rreq}, 32'd0);
        check("rd_m1_noack", {31'd0, m1_ack}, 32'd0);
        m0_req = 1'b0;
        step();
        check("rd_ack_pulse", {31'd0, m0_ack}, 32'd0);
        check("rd_rdata_hold", m0_rdata, 32'h000000ff);
        // single write on port 1, with a stray read-valid ignored
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8; m1_wdata = 32'hdead; m1_be = 4'b0011;
        step();
        check("wr_wreq", {31'd0, dc_wreq}, 32'd1);
        check("wr_rreq", {31'd0, dc_rreq}, 32'd0);
        check("wr_addr", dc_addr, 32'h8);
        check("wr_wdata", dc_wdata, 32'hdead);
        check("wr_be", {28'd0, dc_be}, 32'h3);
        dc_rvalid = 1'b1; dc_rdata = 32'h5555;
        step();
        dc_rvalid = 1'b0;
        check("wr_wrongvalid_noack", {31'd0, m1_ack}, 32'd0);
        check("wr_wrongvalid_hold", {31'd0, dc_wreq}, 32'd1);
        dc_wvalid = 1'b1;
        step();
        dc_wvalid = 1'b0;
        check("wr_ack", {31'd0, m1_ack}, 32'd1);
        check("wr_err", {31'd0, m1_err}, 32'd0);
        check("wr_wreq_drop", {31'd0, dc_wreq}, 32'd0);
        m1_req = 1'b0;
        step();
        check("wr_ack_pulse", {31'd0, m1_ack}, 32'd0);
        // read on port 0 with a stray write-valid ignored
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'hc;
        step();
        check("wt_rreq", {31'd0, dc_rreq}, 32'd1);
        dc_wvalid = 1'b1;
        step();
        dc_wvalid = 1'b0;
        check("wt_noack", {31'd0, m0_ack}, 32'd0);
        check("wt_rreq_hold", {31'd0, dc_rreq}, 32'd1);
        dc_rvalid = 1'b1; dc_rdata = 32'h1234;
        step();
        dc_rvalid = 1'b0;
        check("wt_ack", {31'd0, m0_ack}, 32'd1);
        check("wt_rdata", m0_rdata, 32'h1234);
        m0_req = 1'b0;
        step();
        // timeout: cache silent, 8 ACCESS cycles then error ack
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        step();
        check("to_rreq", {31'd0, dc_rreq}, 32'd1);
        for (int i = 0; i < 7; i++) step();
        check("to_still_waiting", {31'd0, m0_ack}, 32'd0);
        check("to_rreq_hold", {31'd0, dc_rreq}, 32'd1);
        step();
        check("to_ack", {31'd0, m0_ack}, 32'd1);
        check("to_err", {31'd0, m0_err}, 32'd1);
        check("to_rdata", m0_rdata, 32'd0);
        check("to_rreq_drop", {31'd0, dc_rreq}, 32'd0);
        m0_req = 1'b0;
        step();
        check("to_clear", {30'd0, m0_ack, m0_err}, 32'd0);
        // async reset while a read is in flight
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
        step();
        check("ar_rreq", {31'd0, dc_rreq}, 32'd1);
        #2 rst_n = 1'b0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h200; m1_wdata = 32'h55; m1_be = 4'hf;
        #1;
        check("ar_rreq_drop", {31'd0, dc_rreq}, 32'd0);
        check("ar_addr_clear", dc_addr, 32'd0);
        step();
        check("ar_noack", {30'd0, m0_ack, m1_ack}, 32'd0);
        m0_addr = 32'h100;
        rst_n = 1'b1;
        // contention: both request continuously, grants must alternate starting with port 0
        for (int i = 0; i < 8; i++) begin
            step();
            check("ct_addr", dc_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
            check("ct_rreq", {31'd0, dc_rreq}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) begin
                dc_rvalid = 1'b1; dc_rdata = 32'ha0 + i;
            end else begin
                dc_wvalid = 1'b1;
            end
            step();
            dc_rvalid = 1'b0; dc_wvalid = 1'b0;
            check("ct_ack0", {31'd0, m0_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("ct_ack1", {31'd0, m1_ack}, (i % 2 == 0) ? 32'd0 : 32'd1);
            acks0 += int'(m0_ack);
            acks1 += int'(m1_ack);
            if (i % 2 == 0) check("ct_rdata", m0_rdata, 32'ha0 + i);
            step();
        end
        check("ct_count0", acks0, 32'd4);
        check("ct_count1", acks1, 32'd4);
        m0_req = 1'b0; m1_req = 1'b0;
        step(); step();
        check("end_idle", {30'd0, dc_rreq, dc_wreq}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_arbiter.md
Name: dcache_arbiter

Overview:
- Shares the single-ported dcache between two requesters: port 0 is the core load/store unit, port 1 is a debug/DMA master.
- Grants one transaction at a time using round-robin priority and holds the grant until the dcache signals completion or a timeout fires.
- All dcache-side outputs are registered, and each requester gets a one-cycle ack carrying rdata and an error flag.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte_enable width is DATA_W/8.
- TIMEOUT, 64, maximum cycles in ACCESS before aborting with error (must be ≥2).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- m0_req  in  1  port 0 request; held high until m0_ack
- m0_we  in  1  1 = write, 0 = read; stable while req
- m0_addr  in  ADDR_W  word address; stable while req
- m0_wdata  in  DATA_W  write data
- m0_be  in  DATA_W/8  byte enables (writes only)
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  valid with m0_ack; 1 = timed out
- m0_rdata  out  DATA_W  read data, valid with m0_ack
- m1_req/m1_we/m1_addr/m1_wdata/m1_be/m1_ack/m1_err/m1_rdata: identical semantics for port 1
- dc_addr  out  ADDR_W  to dcache addr
- dc_wreq  out  1  to dcache wreq
- dc_rreq  out  1  to dcache rreq
- dc_wdata  out  DATA_W  to dcache wdata
- dc_byte_enable  out  DATA_W/8  to dcache byte_enable
- dc_wvalid  in  1  dcache write done
- dc_rvalid  in  1  dcache read data valid
- dc_rdata  in  DATA_W  dcache read data

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, last_grant=1 (so port 0 wins the first tie), timeout counter=0. All outputs are 0: dc_* zero, wreq/rreq low, acks, errs and rdata zero.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, select a winner. With a single requester, that requester wins. With both high, the port other than last_grant wins.
  - Latch the winner's we/addr/wdata/be into the dc_* registers, assert dc_wreq (we=1) or dc_rreq (we=0), update last_grant, clear the counter, and go to ACCESS.
- ACCESS:
  - Hold dc_* stable and increment the counter each cycle.
  - A write completes on dc_wvalid=1. A read completes on dc_rvalid=1, and dc_rdata is captured into the granted port's rdata register. A valid of the wrong type is ignored.
  - On completion: drop dc_wreq/dc_rreq, set the granted port's ack=1 and err=0, and go to RESP.
  - If the counter reaches TIMEOUT-1 with no completion: drop the request, set ack=1, err=1, rdata=0, and go to RESP.
  - If completion and timeout coincide, completion wins (err=0).
- RESP: ack/err are high for exactly this one cycle. Return to IDLE, clearing ack and err. rdata holds its value until the next ack to that port.
- Latency: req sampled at edge N; dc request is visible after N; earliest ack is after N+1 (when the cache responds in the first ACCESS cycle). Minimum period between grants is 3 cycles.
- Requester rule: deassert req at the edge where ack=1 is sampled. Because IDLE samples only on the following edge, a request is never double-issued.
- The arbiter never starts a dcache request while another is in flight. Requests from the non-granted port are held pending, not dropped.
- dc_wreq and dc_rreq are never high simultaneously.
- A req that drops while in ACCESS is ignored: the transaction completes and ack is still pulsed.
- Reset asserted mid-transaction aborts immediately to IDLE with no ack.

Test Plan:
- Single read: m0_req=1, we=0, addr=0x4; cache returns rvalid with rdata=0x000000ff → dc_rreq high until rvalid, m0_ack pulses 1 cycle later, m0_rdata=0x000000ff, m0_err=0.
- Single write: m1_req=1, we=1, addr=0x8, wdata=0xdead, be=4'b0011 → dc_wreq high, dc_wdata=0xdead, dc_byte_enable=0011 on the dcache side, m1_ack on completion.
- Contention: both ports request continuously after reset → grants alternate 0,1,0,1 and dc_addr alternates between the two ports' addresses. Four transactions complete per port with no starvation.
- Timeout: TIMEOUT=8, cache never asserts valid → after 8 ACCESS cycles m0_ack=1, m0_err=1, m0_rdata=0, and the arbiter returns to IDLE and serves the next request.
- Wrong-type valid: a read is in flight and dc_wvalid=1 arrives → no completion; completion occurs only on the later dc_rvalid.
- Async reset mid-ACCESS: rst=0 while dc_rreq=1 → dc_rreq drops immediately, no ack is issued, and after release port 0 is granted first.
